// File: rtl/clk_rst_pkg.sv
// Shared constants for the clock-divider slice: counter width, divider taps
// and the helper that folds the OFFSET parameter into a legal counter preset.
package clk_rst_pkg;

    // Width of the free-running divider counter; 2**CNT_W is the longest period.
    localparam int CNT_W = 9;

    // Counter bit tapped for each divided output; the period is 2**(tap+1).
    localparam int TAP_2   = 0;
    localparam int TAP_32  = 4;
    localparam int TAP_512 = 8;

    // Largest preset that fits the counter without truncation.
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Reduce an arbitrary integer preset to the counter width (drop upper bits).
    function automatic logic [CNT_W-1:0] preset_of(input int off);
        return CNT_W'(off);
    endfunction

endpackage : clk_rst_pkg

// File: rtl/clk_rst_cnt.sv
// Generic free-running up-counter with an asynchronous, active-high preset.
// Wraps naturally at 2**WIDTH; INIT is loaded for as long as rst is high.
module clk_rst_cnt #(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Next count: plain increment, the wrap to zero falls out of the width.
    always_comb begin
        // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
        cnt_d = cnt_q + WIDTH'(1);
    end

    // Counter register: preset asynchronously, advance on every rising edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
        if (rst) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : clk_rst_cnt

// File: rtl/clk_rst.sv
// Clock divider: derives /2, /32 and /512 clocks (50% duty) from clk using a
// single 9-bit counter. OFFSET presets the counter and so sets the phase of
// every output relative to reset release. Outputs are raw register bits so
// they are glitch-free; consumers own any clock-domain crossing.
module clk_rst
    import clk_rst_pkg::*;
#(
    parameter int OFFSET = 0
) (
    input  logic clk,
    input  logic rst,
    output logic clk_2,
    output logic clk_32,
    output logic clk_512
);

    // Preset truncated to the counter width; larger values keep only low bits.
    localparam logic [CNT_W-1:0] RST_VAL = preset_of(OFFSET);

    // Tell the integrator when the requested phase cannot be represented.
    if (OFFSET < 0 || OFFSET > CNT_MAX) begin : g_offset_warn
        $warning("clk_rst: OFFSET=%0d outside 0..%0d, truncated to %0d",
                 OFFSET, CNT_MAX, RST_VAL);
    end

    logic [CNT_W-1:0] cnt;

    // Single shared counter; all divided clocks are taps of it.
    clk_rst_cnt #(
        .WIDTH (CNT_W),
        .INIT  (RST_VAL)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .cnt (cnt)
    );

    // Direct taps: no logic between flop and port, hence no glitches.
    assign clk_2   = cnt[TAP_2];
    assign clk_32  = cnt[TAP_32];
    assign clk_512 = cnt[TAP_512];

endmodule : clk_rst

// File: tb/tb_clk_rst.sv
// Bench for clk_rst: two instances (OFFSET=5 and OFFSET=0) share clock and
// reset. A hand-derived vector table pins the key transition edges, an
// arithmetic reference model checks every edge, and randomized asynchronous
// reset pulses exercise mid-count reset and restart.
module tb_clk_rst;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic a_2, a_32, a_512;   // OFFSET = 5
    logic b_2, b_32, b_512;   // OFFSET = 0

    int n_vec = 0;
    int n_bad = 0;
    int e     = 0;            // rising edges since the last reset release
    bit tbl_on = 1'b0;

    always #5 clk = ~clk;

    clk_rst #(.OFFSET(5)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .clk_2   (a_2),
        .clk_32  (a_32),
        .clk_512 (a_512)
    );

    clk_rst #(.OFFSET(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .clk_2   (b_2),
        .clk_32  (b_32),
        .clk_512 (b_512)
    );

    // Expected {clk_512, clk_32, clk_2}: count value after e edges, then
    // the output is high in the upper half of each divided period.
    function automatic logic [2:0] model(input int off, input int edges);
        int c;
        c = (off + edges) % 512;
        return {1'((c / 256) % 2), 1'((c / 16) % 2), 1'(c % 2)};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (t=%0t edge=%0d): got {512,32,2}=%b expected %b",
                     name, $time, e, act, exp);
        end
    endtask

    typedef struct {
        int         off;
        int         edge_n;
        logic [2:0] exp;      // {clk_512, clk_32, clk_2}
    } vec_t;

    vec_t tbl[$];

    // Compare both instances after the edge just taken.
    task automatic check_edge();
        check("model_off5", {a_512, a_32, a_2}, model(5, e));
        check("model_off0", {b_512, b_32, b_2}, model(0, e));
        if (tbl_on) begin
            foreach (tbl[i]) begin
                if (tbl[i].edge_n == e) begin
                    if (tbl[i].off == 5)
                        check($sformatf("tbl_off5_e%0d", e), {a_512, a_32, a_2}, tbl[i].exp);
                    else
                        check($sformatf("tbl_off0_e%0d", e), {b_512, b_32, b_2}, tbl[i].exp);
                end
            end
        end
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e++;
            check_edge();
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_off5"}, {a_512, a_32, a_2}, 3'b001);
        check({name, "_off0"}, {b_512, b_32, b_2}, 3'b000);
    endtask

    // Reset asserted between edges (2..4 ns after a rising edge), held for a
    // few edges, then released on a falling edge.
    task automatic async_reset(input string name, input int hold);
        @(posedge clk);
        #($urandom_range(2, 4));
        rst = 1'b1;
        #0.5;
        check_reset_vals({name, "_now"});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_reset_vals({name, "_hold"});
        end
        @(negedge clk);
        rst = 1'b0;
        e = 0;
    endtask

    initial begin
        // Hand-derived transition points, {clk_512, clk_32, clk_2}.
        tbl.push_back('{5,   1, 3'b000});   // cnt 6
        tbl.push_back('{5,   2, 3'b001});   // cnt 7
        tbl.push_back('{5,  10, 3'b011 & 3'b001}); // cnt 15: only clk_2 high
        tbl.push_back('{5,  11, 3'b010});   // cnt 16: clk_32 rises
        tbl.push_back('{5,  26, 3'b011});   // cnt 31
        tbl.push_back('{5,  27, 3'b000});   // cnt 32: clk_32 falls
        tbl.push_back('{5,  43, 3'b010});   // cnt 48: next clk_32 rise
        tbl.push_back('{5, 250, 3'b011});   // cnt 255
        tbl.push_back('{5, 251, 3'b100});   // cnt 256: clk_512 rises
        tbl.push_back('{5, 506, 3'b111});   // cnt 511
        tbl.push_back('{5, 507, 3'b000});   // cnt 0: clk_512 falls
        tbl.push_back('{5, 763, 3'b100});   // cnt 256 again: period 512
        tbl.push_back('{0,   1, 3'b001});
        tbl.push_back('{0,  15, 3'b001});   // cnt 15
        tbl.push_back('{0,  16, 3'b010});   // clk_32 rises
        tbl.push_back('{0,  32, 3'b000});
        tbl.push_back('{0, 255, 3'b011});
        tbl.push_back('{0, 256, 3'b100});   // clk_512 rises
        tbl.push_back('{0, 512, 3'b000});

        // Reset takes effect before any clock edge (first rising edge at 5 ns).
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_no_edge");

        // Held through several edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_vals("rst_held");
        end

        // Release and run past two full slow periods.
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        tbl_on = 1'b1;
        run_edges(1100);
        tbl_on = 1'b0;

        // Mid-count reset with the OFFSET=5 counter at 300.
        async_reset("rst_pre300", 1);
        run_edges(295);
        check("cnt300_off5", {a_512, a_32, a_2}, 3'b100);
        async_reset("rst_at300", 4);
        run_edges(40);

        // Randomized run lengths and reset pulses.
        for (int k = 0; k < 6; k++) begin
            run_edges($urandom_range(1, 600));
            async_reset($sformatf("rst_rand%0d", k), $urandom_range(0, 3));
        end
        run_edges(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_clk_rst
